// File: rtl/apb_reg_bridge.sv
// APB4 slave that turns each transfer into a level request/ack handshake on a
// simple register backend, with an optional wait-cycle timeout.
module apb_reg_bridge #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                prst_n,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    output logic                pready,
    output logic [DATA_W-1:0]   prdata,
    output logic                pslverr,
    output logic                wr_req,
    output logic [ADDR_W-1:0]   waddr,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic                wack,
    input  logic                waddrerr,
    output logic                rd_req,
    output logic [ADDR_W-1:0]   raddr,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                rack,
    input  logic                raddrerr
);

    // state   | meaning
    // IDLE    | waiting for an APB setup phase
    // WR_WAIT | wr_req asserted, waiting for wack or timeout
    // RD_WAIT | rd_req asserted, waiting for rack or timeout
    // RESP    | one-cycle pready with registered pslverr/prdata

    localparam int STRB_W  = DATA_W / 8;
    localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, RESP} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic [DATA_W-1:0]   rdata_q, rdata_nxt;
    logic                err_q, err_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                capture;
    logic                timed_out;

    // The last waiting cycle is the one whose count is TIMEOUT-1; an ack in
    // that same cycle is checked first and therefore wins.
    assign timed_out = (TIMEOUT > 0) && (cnt == CNT_W'(TO_LAST));

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            rdata_q <= rdata_nxt;
            err_q   <= err_nxt;
            cnt     <= cnt_nxt;
            if (capture) begin
                addr_q  <= paddr;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err_q;
        rdata_nxt = rdata_q;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt   = '0;
                err_nxt   = 1'b0;
                rdata_nxt = '0;
                if (psel && !penable) begin
                    capture = 1'b1;
                    if (!pwrite)
                        state_nxt = RD_WAIT;
                    else if (pstrb == '0)
                        state_nxt = RESP;
                    else
                        state_nxt = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (wack) begin
                    state_nxt = RESP;
                    err_nxt   = waddrerr;
                end else if (timed_out) begin
                    state_nxt = RESP;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RD_WAIT: begin
                if (rack) begin
                    state_nxt = RESP;
                    err_nxt   = raddrerr;
                    rdata_nxt = raddrerr ? '0 : rdata;
                end else if (timed_out) begin
                    state_nxt = RESP;
                    err_nxt   = 1'b1;
                    rdata_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign pready  = (state == RESP);
    assign pslverr = (state == RESP) && err_q;
    assign prdata  = (state == RESP) ? rdata_q : '0;
    assign wr_req  = (state == WR_WAIT);
    assign rd_req  = (state == RD_WAIT);
    assign waddr   = addr_q;
    assign raddr   = addr_q;
    assign wdata   = wdata_q;
    assign wstrb   = strb_q;

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Directed bench for apb_reg_bridge: writes, reads, timeout, errors, and
// asynchronous reset in the middle of a transfer.
module tb_apb_reg_bridge;

    logic        pclk = 1'b0;
    logic        prst_n = 1'b0;
    logic [11:0] paddr = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic        pready, pslverr, wr_req, rd_req;
    logic [31:0] prdata, wdata;
    logic [11:0] waddr, raddr;
    logic [3:0]  wstrb;
    logic        wack = 1'b0, waddrerr = 1'b0, rack = 1'b0, raddrerr = 1'b0;
    logic [31:0] rdata = '0;

    int total = 0;
    int bad = 0;

    int          reqs, lat;
    logic        err, stable, pr_after;
    logic [31:0] data;

    apb_reg_bridge #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(16)) dut (
        .pclk(pclk), .prst_n(prst_n), .paddr(paddr), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .wr_req(wr_req), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .wack(wack), .waddrerr(waddrerr),
        .rd_req(rd_req), .raddr(raddr), .rdata(rdata),
        .rack(rack), .raddrerr(raddrerr)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    // One APB transfer starting from an IDLE cycle. ack_at = request cycle in
    // which the ack is given (0 = never). Returns positioned in the IDLE
    // cycle after RESP so a following call is back-to-back.
    task automatic xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int ack_at, input logic aerr,
                        input logic [31:0] rd, output int nreq, output int nlat,
                        output logic e, output logic [31:0] q, output logic st,
                        output logic pa);
        nreq = 0; nlat = 0; e = 1'b0; q = '0; st = 1'b1; pa = 1'b1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a;
        pwdata = d; pstrb = s; rdata = rd;
        tick;
        penable = 1'b1;
        nlat = 1;
        for (int i = 0; i < 40; i++) begin
            if (pready) begin
                e = pslverr;
                q = prdata;
                break;
            end
            if (wr ? wr_req : rd_req) begin
                nreq++;
                if (wr ? (waddr !== a || wdata !== d || wstrb !== s) : (raddr !== a))
                    st = 1'b0;
            end
            wack = 1'b0; waddrerr = 1'b0; rack = 1'b0; raddrerr = 1'b0;
            if (ack_at > 0 && nreq == ack_at) begin
                if (wr) begin wack = 1'b1; waddrerr = aerr; end
                else    begin rack = 1'b1; raddrerr = aerr; end
            end
            tick;
            nlat++;
        end
        wack = 1'b0; waddrerr = 1'b0; rack = 1'b0; raddrerr = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        tick;
        pa = pready;
    endtask

    initial begin
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_wr_req", 32'(wr_req), 32'd0);
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        prst_n = 1'b1;
        tick;

        // write, ack in third request cycle
        xfer(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 3, 1'b0, 32'h0, reqs, lat, err, data, stable, pr_after);
        chk("wr_req_cycles", 32'(reqs), 32'd3);
        chk("wr_latency", 32'(lat), 32'd4);
        chk("wr_pslverr", 32'(err), 32'd0);
        chk("wr_stable", 32'(stable), 32'd1);
        chk("wr_pready_one_cycle", 32'(pr_after), 32'd0);
        chk("wr_waddr", 32'(waddr), 32'h010);
        chk("wr_wstrb", 32'(wstrb), 32'hF);

        // read, ack in first request cycle (back-to-back with the write)
        xfer(1'b0, 12'h020, 32'h0, 4'h0, 1, 1'b0, 32'h12345678, reqs, lat, err, data, stable, pr_after);
        chk("rd_req_cycles", 32'(reqs), 32'd1);
        chk("rd_latency", 32'(lat), 32'd2);
        chk("rd_prdata", data, 32'h12345678);
        chk("rd_pslverr", 32'(err), 32'd0);
        chk("rd_stable", 32'(stable), 32'd1);
        chk("rd_prdata_idle", prdata, 32'd0);

        // write with empty strobe skips the backend
        xfer(1'b1, 12'h030, 32'h11111111, 4'h0, 1, 1'b0, 32'h0, reqs, lat, err, data, stable, pr_after);
        chk("nostrb_req_cycles", 32'(reqs), 32'd0);
        chk("nostrb_latency", 32'(lat), 32'd1);
        chk("nostrb_pslverr", 32'(err), 32'd0);

        // write with address error
        xfer(1'b1, 12'h034, 32'h22222222, 4'h3, 2, 1'b1, 32'h0, reqs, lat, err, data, stable, pr_after);
        chk("wrerr_latency", 32'(lat), 32'd3);
        chk("wrerr_pslverr", 32'(err), 32'd1);
        chk("wrerr_pslverr_idle", 32'(pslverr), 32'd0);

        // read with no ack times out after 16 request cycles
        xfer(1'b0, 12'h040, 32'h0, 4'h0, 0, 1'b0, 32'hAAAA5555, reqs, lat, err, data, stable, pr_after);
        chk("to_req_cycles", 32'(reqs), 32'd16);
        chk("to_latency", 32'(lat), 32'd17);
        chk("to_pslverr", 32'(err), 32'd1);
        chk("to_prdata", data, 32'd0);

        // read with address error returns zero data
        xfer(1'b0, 12'h048, 32'h0, 4'h0, 2, 1'b1, 32'hFFFF0000, reqs, lat, err, data, stable, pr_after);
        chk("rderr_pslverr", 32'(err), 32'd1);
        chk("rderr_prdata", data, 32'd0);

        // spurious ack/error in IDLE is ignored
        rack = 1'b1; raddrerr = 1'b1; wack = 1'b1; waddrerr = 1'b1; rdata = 32'h5A5A5A5A;
        tick;
        tick;
        chk("spur_pready", 32'(pready), 32'd0);
        chk("spur_pslverr", 32'(pslverr), 32'd0);
        chk("spur_rd_req", 32'(rd_req), 32'd0);
        rack = 1'b0; raddrerr = 1'b0; wack = 1'b0; waddrerr = 1'b0;

        // ack in the same cycle the timeout would fire: ack wins
        xfer(1'b0, 12'h050, 32'h0, 4'h0, 16, 1'b0, 32'hCAFEF00D, reqs, lat, err, data, stable, pr_after);
        chk("race_req_cycles", 32'(reqs), 32'd16);
        chk("race_latency", 32'(lat), 32'd17);
        chk("race_pslverr", 32'(err), 32'd0);
        chk("race_prdata", data, 32'hCAFEF00D);

        // asynchronous reset in RD_WAIT
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h0AB;
        tick;
        penable = 1'b1;
        tick;
        chk("mid_rd_req", 32'(rd_req), 32'd1);
        chk("mid_raddr", 32'(raddr), 32'h0AB);
        prst_n = 1'b0;
        #1;
        chk("arst_rd_req", 32'(rd_req), 32'd0);
        chk("arst_raddr", 32'(raddr), 32'd0);
        chk("arst_pready", 32'(pready), 32'd0);
        psel = 1'b0; penable = 1'b0;
        #2;
        prst_n = 1'b1;
        tick;

        xfer(1'b0, 12'h044, 32'h0, 4'h0, 1, 1'b0, 32'h0BADF00D, reqs, lat, err, data, stable, pr_after);
        chk("post_rst_latency", 32'(lat), 32'd2);
        chk("post_rst_prdata", data, 32'h0BADF00D);
        chk("post_rst_pslverr", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_reg_bridge.md
APB_REG_BRIDGE -- requirements
Module: apb_reg_bridge

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- ADDR_W, 12, APB and backend address width.
- DATA_W, 32, data width; multiple of 8.
- TIMEOUT, 16, max backend wait cycles; 0 disables timeout.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- pclk, in, 1, single clock.
- prst_n, in, 1, asynchronous active-low reset.
- paddr, in, ADDR_W, APB address.
- psel / penable / pwrite, in, 1 each, APB control.
- pwdata, in, DATA_W, APB write data.
- pstrb, in, DATA_W/8, APB4 byte strobes.
- pready, out, 1, transfer complete.
- prdata, out, DATA_W, read data.
- pslverr, out, 1, transfer error.
- wr_req, out, 1, backend write request (level).
- waddr, out, ADDR_W, backend write address.
- wdata, out, DATA_W, backend write data.
- wstrb, out, DATA_W/8, backend byte enables.
- wack / waddrerr, in, 1 each, write done / write address error.
- rd_req, out, 1, backend read request (level).
- raddr, out, ADDR_W, backend read address.
- rdata, in, DATA_W, backend read data.
- rack / raddrerr, in, 1 each, read done / read address error.

Function
REQ-003 SHALL implement FSM states IDLE, WR_WAIT, RD_WAIT, RESP.
REQ-004 In IDLE with psel=1 and penable=0 (setup phase), SHALL capture paddr, pwdata and pstrb, then go to WR_WAIT if pwrite=1, else RD_WAIT.
REQ-005 SHALL drive wr_req=1 throughout WR_WAIT and rd_req=1 throughout RD_WAIT, with waddr/wdata/wstrb or raddr held stable at the captured values.
REQ-006 Write with pstrb all zero SHALL skip WR_WAIT and go directly to RESP with pslverr=0; no wr_req is issued.
REQ-007 In WR_WAIT, wack=1 SHALL move to RESP on the next edge and register pslverr=waddrerr; the request drops in the same edge.
REQ-008 In RD_WAIT, rack=1 SHALL move to RESP, register prdata=rdata and pslverr=raddrerr; if raddrerr=1, prdata SHALL be 0.
REQ-009 Timeout counter SHALL clear on entry to each WAIT state and increment each WAIT cycle without ack; on reaching TIMEOUT, go to RESP with pslverr=1 and prdata=0. Counter width is clog2(TIMEOUT+1).
REQ-010 An ack in the same cycle the counter reaches TIMEOUT SHALL win; the ack is reported and no timeout error is raised.
REQ-011 RESP SHALL assert pready=1 for exactly one cycle, then return to IDLE; outside RESP, pready=0, pslverr=0 and prdata=0.
REQ-012 Minimum latency: setup at edge T, request asserted T+1, ack at T+1 gives pready at T+2, so the access phase has at least one wait state.
REQ-013 wack, rack, waddrerr and raddrerr SHALL be ignored outside the matching WAIT state; rdata is sampled only with rack.
REQ-014 psel dropped mid-transfer (protocol violation) SHALL NOT abort; the FSM completes through RESP normally.
REQ-015 A new setup phase is accepted only in IDLE; back-to-back transfers SHALL cost no extra idle cycle beyond the APB setup cycle.

Reset
REQ-016 prst_n=0 SHALL asynchronously force IDLE, zero the counter and zero every output, including mid-transfer; the backend SHALL tolerate a dropped request.
REQ-017 After reset release, the first accepted transfer SHALL begin on the first setup phase seen in IDLE.

Verification
REQ-018 Write 0xDEADBEEF to 0x010 with pstrb=0xF, wack after 3 cycles -> wr_req high 3 cycles, waddr=0x010, wstrb=0xF, one pready pulse, pslverr=0.
REQ-019 Read 0x020 with rack on the first cycle and rdata=0x12345678 -> pready at T+2, prdata=0x12345678, pslverr=0.
REQ-020 Read with no ack and TIMEOUT=16 -> rd_req high 16 cycles, then pready=1, pslverr=1, prdata=0.
REQ-021 Write with pstrb=0 -> no wr_req, pready at T+1, pslverr=0; separately, write with wack and waddrerr both 1 -> pslverr=1.
REQ-022 prst_n pulsed low during RD_WAIT -> rd_req, raddr and pready go to 0 immediately; the next read completes normally.
REQ-023 Spurious rack in IDLE, then rack and timeout in the same cycle -> first ignored; second reports rdata with pslverr=raddrerr.
